// File: rtl/rv_regfile_pkg.sv
// Shared defaults for the register file with busy scoreboard.
// Optional write-to-read forwarding is enabled by RV_REGFILE_BYPASS_EN.
package rv_regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NR_READ    = 2;
    localparam int ZERO_REG       = 0;

endpackage

// File: rtl/rv_regfile_rdport.sv
// One combinational read port: stored data and busy lookup.
// Optional same-cycle forwarding of write-back data under RV_REGFILE_BYPASS_EN.
module rv_regfile_rdport
    import rv_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
`ifdef RV_REGFILE_BYPASS_EN
    input  logic                             rst_n,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0]            wb_wdata,
    input  logic                             alloc_fire,
    input  logic [ADDR_WIDTH-1:0]            alloc_rd,
`endif
    input  logic [ADDR_WIDTH-1:0]            raddr,
    input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] mem_flat,
    input  logic [(2**ADDR_WIDTH)-1:0]       busy,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rbusy
);

    logic [DATA_WIDTH-1:0] stored;

    assign stored = mem_flat[int'(raddr)*DATA_WIDTH +: DATA_WIDTH];

`ifdef RV_REGFILE_BYPASS_EN
    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

    logic hit;

    // Forwarding is gated by reset so outputs stay zero while rst_n is low
    assign hit   = rst_n && wb_valid && (wb_rd == raddr) && (raddr != ZR);
    assign rdata = hit ? wb_wdata : stored;
    assign rbusy = hit ? (alloc_fire && (alloc_rd == raddr)) : busy[raddr];
`else
    assign rdata = stored;
    assign rbusy = busy[raddr];
`endif

endmodule

// File: rtl/rv_regfile.sv
// Register file with pending-write scoreboard and busy counter.
// Build with RV_REGFILE_BYPASS_EN to forward write-back data to reads.
module rv_regfile
    import rv_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NR_READ    = DEF_NR_READ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rbusy,
    input  logic                          alloc_valid,
    input  logic [ADDR_WIDTH-1:0]         alloc_rd,
    output logic                          alloc_ready,
    input  logic                          wb_valid,
    input  logic [ADDR_WIDTH-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0]         wb_wdata,
    input  logic                          flush,
    output logic [ADDR_WIDTH:0]           busy_cnt
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0]      mem [NREG];
    logic [NREG*DATA_WIDTH-1:0] mem_flat;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            busy_nxt;
    logic                       wb_en;
    logic                       alloc_fire;
    logic                       alloc_set;
    logic                       cnt_up;
    logic                       cnt_dn;

    assign wb_en       = wb_valid && (wb_rd != ZR);
    assign alloc_ready = rst_n && !flush &&
                         (!busy[alloc_rd] || (wb_valid && (wb_rd == alloc_rd)));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_set   = alloc_fire && (alloc_rd != ZR);

    // Count only real transitions so busy_cnt tracks popcount(busy) exactly
    assign cnt_up = alloc_set && !busy[alloc_rd];
    assign cnt_dn = wb_en && busy[wb_rd] &&
                    !(alloc_set && (alloc_rd == wb_rd));

    always_comb begin
        busy_nxt = busy;
        if (wb_en)     busy_nxt[wb_rd]    = 1'b0;
        if (alloc_set) busy_nxt[alloc_rd] = 1'b1;
        if (flush)     busy_nxt           = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wb_en) begin
            mem[wb_rd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (flush)                busy_cnt <= '0;
            else if (cnt_up && !cnt_dn) busy_cnt <= busy_cnt + CNT_ONE;
            else if (cnt_dn && !cnt_up) busy_cnt <= busy_cnt - CNT_ONE;
        end
    end

    for (genvar j = 0; j < NREG; j++) begin : g_pack
        assign mem_flat[j*DATA_WIDTH +: DATA_WIDTH] = mem[j];
    end

    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        rv_regfile_rdport #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_rd (
`ifdef RV_REGFILE_BYPASS_EN
            .rst_n      (rst_n),
            .wb_valid   (wb_valid),
            .wb_rd      (wb_rd),
            .wb_wdata   (wb_wdata),
            .alloc_fire (alloc_fire),
            .alloc_rd   (alloc_rd),
`endif
            .raddr      (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_flat   (mem_flat),
            .busy       (busy),
            .rdata      (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy      (rbusy[i])
        );
    end

endmodule

// File: tb/tb_rv_regfile.sv
// Directed self-checking bench for rv_regfile (default parameters).
// Covers reset, scoreboard, x0, flush, counter and async reset behaviour.
module tb_rv_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        flush;
    logic [5:0]  busy_cnt;

    int total = 0;
    int bad   = 0;

    rv_regfile dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .rbusy(rbusy), .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_wdata(wb_wdata), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd5;
        wb_rd       = 5'd0;
        wb_wdata    = '0;
        raddr       = '0;
        #2;
        total++;
        if (alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_alloc_ready got=%b exp=0", alloc_ready);
        end
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(31 - i)};
            #1;
            total++;
            if (rdata !== 64'h0 || rbusy !== 2'b00 || busy_cnt !== 6'd0) begin
                bad++;
                $display("FAIL reset_read idx=%0d got=%h/%b/%0d exp=0/00/0",
                         i, rdata, rbusy, busy_cnt);
            end
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_alloc_wb();
        tick();
        raddr       = {5'd5, 5'd5};
        alloc_valid = 1'b1;
        alloc_rd    = 5'd5;
        #1;
        total++;
        if (alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL alloc5_ready got=%b exp=1", alloc_ready);
        end
        tick();
        total++;
        if (busy_cnt !== 6'd1 || rbusy !== 2'b11) begin
            bad++;
            $display("FAIL alloc5_busy got=%0d/%b exp=1/11", busy_cnt, rbusy);
        end
        total++;
        if (alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL realloc5_ready got=%b exp=0", alloc_ready);
        end
        alloc_valid = 1'b0;
        wb_valid    = 1'b1;
        wb_rd       = 5'd5;
        wb_wdata    = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        total++;
        if (rdata !== {2{32'hDEADBEEF}} || rbusy !== 2'b00 || busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL wb5 got=%h/%b/%0d exp=deadbeefdeadbeef/00/0",
                     rdata, rbusy, busy_cnt);
        end
    endtask

    task automatic test_zero();
        raddr       = {5'd0, 5'd0};
        wb_valid    = 1'b1;
        wb_rd       = 5'd0;
        wb_wdata    = 32'h12345678;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        #1;
        total++;
        if (alloc_ready !== 1'b1 || rdata !== 64'h0) begin
            bad++;
            $display("FAIL x0_same_cycle got=%b/%h exp=1/0", alloc_ready, rdata);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata !== 64'h0 || rbusy !== 2'b00 || busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL x0_after got=%h/%b/%0d exp=0/00/0", rdata, rbusy, busy_cnt);
        end
    endtask

    task automatic test_flush();
        alloc_valid = 1'b1;
        alloc_rd = 5'd3; tick();
        alloc_rd = 5'd4; tick();
        alloc_rd = 5'd7; tick();
        alloc_valid = 1'b0;
        total++;
        if (busy_cnt !== 6'd3) begin
            bad++;
            $display("FAIL three_allocs_cnt got=%0d exp=3", busy_cnt);
        end
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_wdata = 32'h000000A5;
        alloc_rd = 5'd9;
        #1;
        total++;
        if (alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_alloc_ready got=%b exp=0", alloc_ready);
        end
        tick();
        idle();
        raddr = {5'd4, 5'd4};
        #1;
        total++;
        if (busy_cnt !== 6'd0 || rdata !== {2{32'h000000A5}} || rbusy !== 2'b00) begin
            bad++;
            $display("FAIL flush_after got=%0d/%h/%b exp=0/a5a5/00",
                     busy_cnt, rdata, rbusy);
        end
        raddr = {5'd7, 5'd3};
        #1;
        total++;
        if (rbusy !== 2'b00) begin
            bad++;
            $display("FAIL flush_busy37 got=%b exp=00", rbusy);
        end
    endtask

    task automatic test_same_index();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd6;
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        wb_wdata = 32'h66;
        #1;
        total++;
        if (alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL same_idx_ready got=%b exp=1", alloc_ready);
        end
        tick();
        idle();
        raddr = {5'd6, 5'd6};
        #1;
        total++;
        if (busy_cnt !== 6'd1 || rbusy !== 2'b11 || rdata !== {2{32'h66}}) begin
            bad++;
            $display("FAIL same_idx got=%0d/%b/%h exp=1/11/66", busy_cnt, rbusy, rdata);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        wb_wdata = 32'h67;
        tick();
        idle();
        #1;
        total++;
        if (busy_cnt !== 6'd0 || rdata[31:0] !== 32'h67) begin
            bad++;
            $display("FAIL same_idx_clear got=%0d/%h exp=0/67", busy_cnt, rdata[31:0]);
        end
    endtask

    task automatic test_counter();
        // wb to a non-busy register must not decrement
        alloc_valid = 1'b1;
        alloc_rd    = 5'd10;
        wb_valid    = 1'b1;
        wb_rd       = 5'd11;
        wb_wdata    = 32'h11;
        tick();
        idle();
        total++;
        if (busy_cnt !== 6'd1) begin
            bad++;
            $display("FAIL cnt_nonbusy_wb got=%0d exp=1", busy_cnt);
        end
        alloc_valid = 1'b1;
        alloc_rd    = 5'd11;
        wb_valid    = 1'b1;
        wb_rd       = 5'd10;
        wb_wdata    = 32'h10;
        tick();
        idle();
        raddr = {5'd11, 5'd10};
        #1;
        total++;
        if (busy_cnt !== 6'd1 || rbusy !== 2'b10) begin
            bad++;
            $display("FAIL cnt_swap got=%0d/%b exp=1/10", busy_cnt, rbusy);
        end
    endtask

    task automatic test_bypass();
        raddr    = {5'd9, 5'd9};
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        wb_wdata = 32'h55;
        #1;
`ifdef RV_REGFILE_BYPASS_EN
        total++;
        if (rdata !== {2{32'h55}} || rbusy !== 2'b00) begin
            bad++;
            $display("FAIL bypass_same got=%h/%b exp=5555/00", rdata, rbusy);
        end
`else
        total++;
        if (rdata !== 64'h0) begin
            bad++;
            $display("FAIL nobypass_old got=%h exp=0", rdata);
        end
`endif
        tick();
        idle();
        #1;
        total++;
        if (rdata !== {2{32'h55}}) begin
            bad++;
            $display("FAIL bypass_next got=%h exp=5555", rdata);
        end
    endtask

    task automatic test_async_reset();
        wb_valid    = 1'b1;
        wb_rd       = 5'd12;
        wb_wdata    = 32'h77;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd13;
        raddr       = {5'd12, 5'd5};
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rdata !== 64'h0 || busy_cnt !== 6'd0 || alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%h/%0d/%b exp=0/0/0",
                     rdata, busy_cnt, alloc_ready);
        end
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        raddr = {5'd13, 5'd12};
        #1;
        total++;
        if (rdata !== 64'h0 || rbusy !== 2'b00 || busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL rst_no_land got=%h/%b/%0d exp=0/00/0", rdata, rbusy, busy_cnt);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd12;
        wb_wdata = 32'h99;
        tick();
        idle();
        #1;
        total++;
        if (rdata[31:0] !== 32'h99) begin
            bad++;
            $display("FAIL first_write got=%h exp=99", rdata[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_wb();
        test_zero();
        test_flush();
        test_same_index();
        test_counter();
        test_bypass();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_regfile.md
RV_REGFILE -- requirements
Module: rv_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width (2**ADDR_WIDTH entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-003 SHALL have parameter NR_READ, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port raddr  in  NR_READ*ADDR_WIDTH  read indices, port i at slice i.
REQ-007 SHALL have port rdata  out  NR_READ*DATA_WIDTH  read data, port i at slice i.
REQ-008 SHALL have port rbusy  out  NR_READ  per-port flag: indexed register has a pending write.
REQ-009 SHALL have port alloc_valid  in  1  request to mark alloc_rd pending.
REQ-010 SHALL have port alloc_rd  in  ADDR_WIDTH  destination being allocated.
REQ-011 SHALL have port alloc_ready  out  1  allocation accepted this cycle.
REQ-012 SHALL have port wb_valid  in  1  write-back strobe.
REQ-013 SHALL have port wb_rd  in  ADDR_WIDTH  write-back index.
REQ-014 SHALL have port wb_wdata  in  DATA_WIDTH  write-back data.
REQ-015 SHALL have port flush  in  1  discard all pending allocations.
REQ-016 SHALL have port busy_cnt  out  ADDR_WIDTH+1  count of pending registers.

Function
REQ-017 Index 0 SHALL read as 0, ignore writes, never be busy; alloc_ready=1 for alloc_rd=0 with no state change.
REQ-018 Reads SHALL be combinational (zero latency); rbusy[i] = busy[raddr_i].
REQ-019 wb_valid with wb_rd!=0 SHALL write wb_wdata at the next edge and clear busy[wb_rd]; writes to non-busy registers are permitted.
REQ-020 alloc_ready SHALL be !flush && (!busy[alloc_rd] || (wb_valid && wb_rd==alloc_rd)); accept = alloc_valid && alloc_ready.
REQ-021 Accepted alloc with alloc_rd!=0 SHALL set busy[alloc_rd] at the next edge.
REQ-022 Simultaneous accepted alloc and wb to the same index: data written, busy ends 1 (set wins).
REQ-023 flush SHALL clear every busy bit at the next edge; wb in the same cycle still writes data.
REQ-024 busy_cnt SHALL equal popcount(busy) every cycle, maintained as an up/down counter (+1 set, -1 clear, both/neither 0; flush loads 0); never wraps, max 2**ADDR_WIDTH-1.
REQ-025 Multiple read ports addressing the same index SHALL return identical data and busy.

Reset
REQ-026 rst_n low SHALL immediately clear all data registers to 0, all busy bits, and busy_cnt, independent of clk.
REQ-027 During reset, rdata=0, rbusy=0, busy_cnt=0, alloc_ready=0; any in-flight alloc/wb is dropped.
REQ-028 First write accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro RV_REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 Defined: raddr_i==wb_rd!=0 with wb_valid returns wb_wdata same cycle and rbusy[i]=0 unless a same-index alloc is accepted that cycle.
REQ-031 Undefined: reads return stored array contents and registered busy only; write visible the cycle after.

Structure
REQ-032 Package rv_regfile_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH/NR_READ constants and the zero-register index constant.
REQ-033 Read logic SHALL be sub-module rv_regfile_rdport, instantiated NR_READ times via generate; storage, scoreboard and counter stay in rv_regfile.

Verification
REQ-034 Reset then read all 32 indices on both ports -> rdata=0, rbusy=0, busy_cnt=0.
REQ-035 alloc x5; next cycle alloc x5 again -> alloc_ready=0; wb x5=0xDEADBEEF -> busy clears, read 0xDEADBEEF, busy_cnt 1->0.
REQ-036 wb x0=0x12345678, alloc x0 -> rdata=0, rbusy=0, busy_cnt unchanged.
REQ-037 alloc x3,x4,x7 then flush with wb x4=0xA5 -> busy_cnt=0, x4 reads 0xA5.
REQ-038 Same-cycle wb x9=0x55 and read x9: with RV_REGFILE_BYPASS_EN -> 0x55 same cycle; without -> old value, 0x55 next cycle.
REQ-039 Assert rst_n low mid-cycle after writes and allocs -> outputs zero before next edge; no write lands.
